// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: handshake bundle between four requesters, the arbiter
// and the downstream consumer.
//   master - producer/consumer side (drives requests and out_ready)
//   slave  - arbiter side (drives in_ready and the registered output)
interface mux4_rr_arbiter_if #(
  parameter int W = 4
);

  // Requester side
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic [W-1:0] in_data3;
  logic [3:0]   in_ready;

  // Consumer side
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  modport master (
    output in_valid,
    output in_data0,
    output in_data1,
    output in_data2,
    output in_data3,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  modport slave (
    input  in_valid,
    input  in_data0,
    input  in_data1,
    input  in_data2,
    input  in_data3,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: shares one registered output stage between four
// valid/ready requesters. One requester is granted per cycle; its word is
// steered through a 4:1 mux into a single-entry output register that drains
// under out_valid/out_ready. Full throughput is one word per cycle.
//
// Build option:
//   MUX_ARB_FIXED_PRIO_EN  defined   -> fixed priority, requester 0 highest,
//                                       no rotating pointer.
//                          undefined -> round-robin from a rotating pointer
//                                       that moves to grant+1 on each accept.
module mux4_rr_arbiter #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;

  logic [W-1:0] data_q;
  logic [1:0]   src_q;

  logic         any_valid;
  logic         stage_open;
  logic         accept;
  logic         load;
  logic [1:0]   grant;
  logic [W-1:0] grant_data;

  assign any_valid = |bus.in_valid;

  // The stage can take a word when empty, or when full and draining now.
  // Reset is folded in so in_ready is quiet for the whole reset pulse.
  assign stage_open = (state_q == EMPTY) || bus.out_ready;
  assign accept     = stage_open && any_valid && !rst;

`ifdef MUX_ARB_FIXED_PRIO_EN

  // Fixed priority: lowest-index valid requester wins.
  always_comb begin
    grant = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.in_valid[k]) begin
        grant = 2'(k);
      end
    end
  end

`else

  logic [1:0] ptr_q;

  // Round-robin: first valid requester searching ptr, ptr+1, ptr+2, ptr+3.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    // NOTE: every variable written here gets a value before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    grant = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer advances past the winner only when a word is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (load) begin
      ptr_q <= grant + 2'd1;
    end
  end

`endif

  // Word mux steered by the grant.
  always_comb begin
    unique case (grant)
      2'd0:    grant_data = bus.in_data0;
      2'd1:    grant_data = bus.in_data1;
      2'd2:    grant_data = bus.in_data2;
      default: grant_data = bus.in_data3;
    endcase
  end

  // One-hot ready to the granted requester, only when an accept happens.
  always_comb begin
    bus.in_ready = 4'b0000;
    if (accept) begin
      bus.in_ready = 4'b0001 << grant;
    end
  end

  // Output stage next state: accept fills, drain without accept empties.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          load    = 1'b1;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Output stage state register; reset empties it without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, whatever order the blocks are evaluated in.
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output word and source: loaded on accept, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data register is reset too, so out_data reads 0 after
      // reset rather than stale contents.
      data_q <= '0;
      src_q  <= 2'd0;
    end else if (load) begin
      data_q <= grant_data;
      src_q  <= grant;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed bench for mux4_rr_arbiter. A behavioural
// arbiter model predicts grants; accepted words go into a scoreboard queue
// and are compared when the consumer takes them. Define
// MUX_ARB_FIXED_PRIO_EN for both DUT and bench to exercise the fixed build.
module tb_mux4_rr_arbiter;

  localparam int W = 4;

  typedef struct {
    logic [1:0]   src;
    logic [W-1:0] data;
  } exp_t;

  logic clk;
  logic rst;

  mux4_rr_arbiter_if #(.W(W)) bus ();

  mux4_rr_arbiter #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t         sb[$];
  logic [W-1:0] data_v[4];
  logic [1:0]   m_ptr;
  bit           m_full;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [3:0] iv);
    logic [1:0] g;
    logic [1:0] idx;
    bit         found;
    g     = 2'd0;
    found = 1'b0;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      idx = 2'(k);
      if (!found && iv[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      idx = m_ptr + 2'(k);
      if (!found && iv[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
`endif
    return g;
  endfunction

  task automatic drive_data();
    bus.in_data0 = data_v[0];
    bus.in_data1 = data_v[1];
    bus.in_data2 = data_v[2];
    bus.in_data3 = data_v[3];
  endtask

  task automatic model_reset();
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 2'd0;
  endtask

  // One clock cycle: drive, check outputs/ready, update model, step the clock.
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic [3:0] iv, input logic ordy);
    logic [3:0] exp_rdy;
    logic [1:0] g;
    bit         open;
    exp_t       e;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    drive_data();
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_full));
    if (m_full && sb.size() > 0) begin
      e = sb[0];
      check("out_data", 32'(bus.out_data), 32'(e.data));
      check("out_src", 32'(bus.out_src), 32'(e.src));
      if (ordy) void'(sb.pop_front());
    end
    open    = !m_full || ordy;
    g       = model_grant(iv);
    exp_rdy = (open && (|iv)) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (open && (|iv)) begin
      sb.push_back('{src: g, data: data_v[g]});
      m_ptr  = g + 2'd1;
      m_full = 1'b1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    data_v[0] = 4'h1;
    data_v[1] = 4'h2;
    data_v[2] = 4'h3;
    data_v[3] = 4'h4;
    drive_data();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    model_reset();

    // Reset holds everything quiet even with all requesters valid.
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_src", 32'(bus.out_src), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming, all valid: grants 0,1,2,3,0 then 1 (word 0x2 from req 1).
    repeat (6) cycle(4'b1111, 1'b1);
    // Backpressure: word 0x2/src 1 held, no ready.
    repeat (3) cycle(4'b1111, 1'b0);
    // Release: next grant continues the rotation.
    cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);

    // Sparse and wrap: only req 3, idle, only req 0, then all valid.
    data_v[3] = 4'hA;
    cycle(4'b1000, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);
    data_v[0] = 4'h5;
    cycle(4'b0001, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);

    // Reset mid-operation: fill the stage and stall, then reset off-edge.
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("async_rst_out_data", 32'(bus.out_data), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Requesters 2 and 0 both valid: 0 first, then 2.
    cycle(4'b0101, 1'b1);
    cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b1);

    // Two competitors 1 and 2, then only 2 (fixed build: 1,1,1,1,2).
    cycle(4'b0110, 1'b1);
    cycle(4'b0110, 1'b1);
    cycle(4'b0110, 1'b1);
    cycle(4'b0110, 1'b1);
    cycle(4'b0100, 1'b1);

    // Final drain: everything accepted must have been delivered.
    repeat (2) cycle(4'b0000, 1'b1);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for a shared 4:1 word mux. Four requesters each offer a W-bit word under valid/ready. The block chooses one requester per cycle, steers its word through the mux select, and registers the result into a single-entry output stage with its own valid/ready handshake. It sits in front of any consumer that must be shared fairly between four producers.

## Interface
Parameters:
- W, default 4: data width of every requester word and of the output word.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  4  bit i set means requester i offers in_data_i.
- in_data0, in_data1, in_data2, in_data3  in  W each  requester words.
- in_ready  out  4  bit i set means requester i's word is accepted this cycle; at most one bit set (one-hot or zero).
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered selected word.
- out_src  out  2  index of the requester that supplied out_data.
- out_ready  in  1  consumer takes out_data this cycle when out_valid is also set.

## Operation
- Output stage has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Stage is "open" when in state EMPTY, or in state FULL with out_ready=1 (drain this cycle).
- Grant g is computed combinationally from in_valid and the rotating pointer ptr[1:0]. It is the first requester with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- in_ready[g]=1 only when the stage is open and any in_valid is set. All other in_ready bits are 0. in_ready may depend on in_valid; the reverse is forbidden.
- Accept happens when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data_g, out_src <= g, out_valid <= 1.
  - ptr <= g+1 (mod 4; 3 wraps to 0).
- Drain with no accept: out_valid <= 0. out_data and out_src keep their values.
- Drain and accept in the same cycle: the new word replaces the old one, out_valid stays 1. This gives 1 word/cycle throughput.
- FULL with out_ready=0: out_data and out_src are held stable, all in_ready are 0, ptr is unchanged.
- Requester rule: once in_valid[i] rises, it and in_data_i stay stable until in_ready[i] is seen. The bench checks this; the RTL does not police it.
- ptr changes only on accept. Idle cycles do not rotate it.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is combinational and is 0 while rst=1.
- Reset asserted mid-transfer discards the held word immediately (asynchronous). The first accept after release uses ptr=0.
- Latency: accept in cycle N gives out_valid=1 with that word in cycle N+1.
- With all four requesters continuously valid and out_ready=1, grant order is 0,1,2,3,0,… One word per cycle.
- A single valid requester is granted every cycle it is valid and the stage is open.
- Starvation bound: a waiting requester is granted within 4 accepts.

## Configuration
- MUX_ARB_FIXED_PRIO_EN defined:
  - Grant is always the lowest-index valid requester; requester 0 has highest priority.
  - ptr is not implemented and has no effect.
  - All handshake and output-stage behaviour is identical to the round-robin build.
- Undefined (default): round-robin as described above.

## Test plan
- Reset check: hold rst=1 with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_src=0. First accept after release goes to requester 0.
- Round-robin streaming: in_data0..3=0x1,0x2,0x3,0x4, all valid, out_ready=1 -> out_src sequence 0,1,2,3,0; out_data 1,2,3,4,1 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles while FULL with 0x2 from requester 1 -> out_data=0x2 and out_src=1 held, in_ready=0000. When out_ready returns to 1, the next grant is requester 2 (ptr wrapped correctly).
- Sparse and wrap: only requester 3 valid (0xA), then only requester 0 valid (0x5) -> grants 3 then 0, ptr goes 3->0->1. Idle cycles leave ptr unchanged.
- Reset mid-operation: assert rst while FULL -> out_valid drops in the same cycle without waiting for clk. After release, requesters 2 and 0 both valid -> requester 0 granted first.
- MUX_ARB_FIXED_PRIO_EN build: requesters 1 and 2 held valid -> every grant goes to 1 until requester 1 deasserts, then to 2.
